// File: rtl/gbuff_reader_pkg.sv
// -----------------------------------------------------------------------------
// gbuff_reader_pkg
// Shared widths, FSM state encodings and a small address helper for the
// global-buffer reader. The project-wide widths come from the def.v macros
// (ADDR_WIDTH, WORD_WIDTH, GBRD_FIFO_DEPTH). Fallback values are provided
// here so that the package also elaborates on its own.
// -----------------------------------------------------------------------------
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 6
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 16
`endif
`ifndef GBRD_FIFO_DEPTH
`define GBRD_FIFO_DEPTH 4
`endif

package gbuff_reader_pkg;

    localparam int ADDR_WIDTH      = `ADDR_WIDTH;
    localparam int WORD_WIDTH      = `WORD_WIDTH;
    localparam int GBRD_FIFO_DEPTH = `GBRD_FIFO_DEPTH;

    // The length and counters have one extra bit so that a full-buffer
    // transfer (2^ADDR_WIDTH words) can be represented.
    localparam int LEN_WIDTH = ADDR_WIDTH + 1;

    // Controller states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Buffer address for a given word offset. The address wraps modulo
    // 2^ADDR_WIDTH because only the low bits of the offset are used.
    function automatic logic [ADDR_WIDTH-1:0] buf_addr(
        input logic [ADDR_WIDTH-1:0] base,
        input logic [LEN_WIDTH-1:0]  offset
    );
        return base + offset[ADDR_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO used as the output skid buffer of gbuff_reader.
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   push_i, data_i  : write request and data
//   pop_i, data_o   : read request and head-of-FIFO data
//   full_o, empty_o : occupancy flags
//   count_o         : number of stored entries (0..DEPTH)
// A push on a full FIFO is accepted when a pop happens in the same cycle.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_do_pop;
    logic             w_do_push;

    assign empty_o   = (r_count == {CW{1'b0}});
    assign full_o    = (r_count == CW'(DEPTH));
    assign count_o   = r_count;
    assign data_o    = r_mem[r_rd_ptr];
    assign w_do_pop  = pop_i && !empty_o;
    assign w_do_push = push_i && (!full_o || w_do_pop);

    // Storage array write
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // Pointers and occupancy counter; DEPTH is a power of two so the
    // pointers wrap naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/gbuff_reader.sv
// -----------------------------------------------------------------------------
// gbuff_reader
// Reads len_i consecutive words of a synchronous global buffer starting at
// base_addr_i and streams them out on a valid/ready interface, with m_last_o
// marking the final word.
// Ports:
//   clk_i, rst_ni                 : clock, asynchronous active-low reset
//   start_i, base_addr_i, len_i   : transfer request (ignored while busy)
//   busy_o, done_o                : transfer active / one-cycle completion
//   gb_en_o, gb_we_o, gb_addr_o   : buffer read port (write enable tied 0)
//   gb_data_i                     : buffer data, valid one cycle after a read
//   m_valid_o, m_ready_i,
//   m_data_o, m_last_o            : output stream
// Reads are throttled so that buffered plus in-flight words never exceed the
// skid FIFO depth; returning data is therefore always accepted.
// -----------------------------------------------------------------------------
module gbuff_reader
    import gbuff_reader_pkg::*;
#(
    parameter int FIFO_DEPTH = GBRD_FIFO_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  gb_en_o,
    output logic                  gb_we_o,
    output logic [ADDR_WIDTH-1:0] gb_addr_o,
    input  logic [WORD_WIDTH-1:0] gb_data_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [WORD_WIDTH-1:0] m_data_o,
    output logic                  m_last_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_issued;
    logic [LEN_WIDTH-1:0]  r_popped;
    logic                  r_rd_pend;
    logic                  r_gb_en;
    logic [ADDR_WIDTH-1:0] r_gb_addr;
    logic                  r_busy;
    logic                  r_done;

    logic [1:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] w_base_nxt;
    logic [LEN_WIDTH-1:0]  w_len_nxt;
    logic [LEN_WIDTH-1:0]  w_issued_nxt;
    logic [LEN_WIDTH-1:0]  w_popped_nxt;
    logic                  w_gb_en_nxt;
    logic [ADDR_WIDTH-1:0] w_gb_addr_nxt;
    logic [CW:0]           w_committed_nxt;

    logic [WORD_WIDTH-1:0] w_fifo_data;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [CW-1:0]         w_fifo_count;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_last;

    assign w_pop  = !w_fifo_empty && m_ready_i;
    assign w_last = !w_fifo_empty && (r_popped == (r_len - LEN_WIDTH'(1)));
    // The throttle keeps the FIFO from being full without a pop when data
    // returns; the guard mirrors the FIFO's own acceptance rule.
    assign w_push = r_rd_pend && (!w_fifo_full || w_pop);

    // Words that will occupy the FIFO next cycle: stored words after this
    // cycle's push/pop, plus the read being issued now (it lands next cycle).
    assign w_committed_nxt = {1'b0, w_fifo_count}
                           + {{CW{1'b0}}, r_rd_pend}
                           + {{CW{1'b0}}, r_gb_en}
                           - {{CW{1'b0}}, w_pop};

    // Next-state, transfer bookkeeping and next read decision
    always_comb begin
        w_state_nxt  = r_state;
        w_base_nxt   = r_base;
        w_len_nxt    = r_len;
        w_issued_nxt = r_issued;
        w_popped_nxt = r_popped;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_base_nxt   = base_addr_i;
                    w_len_nxt    = len_i;
                    w_issued_nxt = {LEN_WIDTH{1'b0}};
                    w_popped_nxt = {LEN_WIDTH{1'b0}};
                    if (len_i == {LEN_WIDTH{1'b0}}) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (r_gb_en) begin
                    w_issued_nxt = r_issued + LEN_WIDTH'(1);
                end else begin
                    w_issued_nxt = r_issued;
                end
                if (w_pop) begin
                    w_popped_nxt = r_popped + LEN_WIDTH'(1);
                end else begin
                    w_popped_nxt = r_popped;
                end
                if (w_pop && w_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_gb_en_nxt = (w_state_nxt == ST_RUN)
                   && (w_issued_nxt < w_len_nxt)
                   && (w_committed_nxt < (CW+1)'(FIFO_DEPTH));
        if (w_gb_en_nxt) begin
            w_gb_addr_nxt = buf_addr(w_base_nxt, w_issued_nxt);
        end else begin
            w_gb_addr_nxt = r_gb_addr;
        end
    end

    // Controller registers and registered buffer/status outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_base    <= {ADDR_WIDTH{1'b0}};
            r_len     <= {LEN_WIDTH{1'b0}};
            r_issued  <= {LEN_WIDTH{1'b0}};
            r_popped  <= {LEN_WIDTH{1'b0}};
            r_rd_pend <= 1'b0;
            r_gb_en   <= 1'b0;
            r_gb_addr <= {ADDR_WIDTH{1'b0}};
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_base    <= w_base_nxt;
            r_len     <= w_len_nxt;
            r_issued  <= w_issued_nxt;
            r_popped  <= w_popped_nxt;
            r_rd_pend <= r_gb_en;
            r_gb_en   <= w_gb_en_nxt;
            r_gb_addr <= w_gb_addr_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_done    <= (w_state_nxt == ST_DONE);
        end
    end

    sync_fifo #(
        .WIDTH (WORD_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .data_i  (gb_data_i),
        .pop_i   (w_pop),
        .data_o  (w_fifo_data),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .count_o (w_fifo_count)
    );

    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign gb_en_o   = r_gb_en;
    assign gb_we_o   = 1'b0;
    assign gb_addr_o = r_gb_addr;
    assign m_valid_o = !w_fifo_empty;
    assign m_data_o  = w_fifo_empty ? {WORD_WIDTH{1'b0}} : w_fifo_data;
    assign m_last_o  = w_last;

endmodule

// File: tb/tb_gbuff_reader.sv
module tb_gbuff_reader;
    import gbuff_reader_pkg::*;

    localparam int AW    = ADDR_WIDTH;
    localparam int WW    = WORD_WIDTH;
    localparam int DEPTH = 4;
    localparam int MEMSZ = 1 << AW;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start_i = 1'b0;
    logic [AW-1:0] base_addr_i = '0;
    logic [AW:0]   len_i = '0;
    logic          busy_o, done_o, gb_en_o, gb_we_o;
    logic [AW-1:0] gb_addr_o;
    logic [WW-1:0] gb_data_i = '0;
    logic          m_valid_o;
    logic          m_ready_i = 1'b0;
    logic [WW-1:0] m_data_o;
    logic          m_last_o;

    always #5 clk_i = ~clk_i;

    gbuff_reader #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .base_addr_i(base_addr_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o),
        .gb_en_o(gb_en_o), .gb_we_o(gb_we_o), .gb_addr_o(gb_addr_o),
        .gb_data_i(gb_data_i),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
        .m_data_o(m_data_o), .m_last_o(m_last_o)
    );

    // Buffer model: mem[i] = i, one-cycle read latency
    logic [WW-1:0] mem [MEMSZ];
    initial for (int i = 0; i < MEMSZ; i++) mem[i] = WW'(i);
    always @(posedge clk_i) if (gb_en_o) gb_data_i <= mem[gb_addr_o];

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Scoreboard state
    typedef struct { logic [WW-1:0] data; logic last; } beat_t;
    beat_t         exp_q[$];
    logic [AW-1:0] addr_q[$];
    logic [WW-1:0] acc_log[$];
    logic [AW-1:0] addr_log[$];
    int            n_en = 0, n_acc = 0, done_cyc = 0, last_word = -1;
    logic          busy_exp = 1'b0, done_due = 1'b0, prev_stall = 1'b0, nxt_done;
    logic [WW-1:0] prev_data = '0;
    beat_t         b;

    // Compare process: every cycle out of reset
    always @(negedge clk_i) if (rst_ni) begin
        chk("gb_we_low", gb_we_o, 0);
        if (gb_en_o) begin
            if (addr_q.size() == 0) chk("spurious_gb_en", gb_en_o, 0);
            else chk("gb_addr", gb_addr_o, addr_q.pop_front());
            n_en++;
            addr_log.push_back(gb_addr_o);
            chk("occupancy_bound", ((n_en - n_acc) <= DEPTH), 1);
        end
        if (m_last_o && !m_valid_o) chk("last_without_valid", m_last_o, 0);
        if (m_valid_o) chk("valid_with_expected_word", (exp_q.size() > 0), 1);
        if (prev_stall) begin
            chk("hold_valid", m_valid_o, 1);
            chk("hold_data", m_data_o, prev_data);
        end
        chk("done_o", done_o, done_due);
        chk("busy_o", busy_o, busy_exp);
        if (done_o) done_cyc = cyc;
        nxt_done = 1'b0;
        if (m_valid_o && m_ready_i && exp_q.size() > 0) begin
            b = exp_q.pop_front();
            chk("m_data", m_data_o, b.data);
            chk("m_last", m_last_o, b.last);
            if (b.last) nxt_done = 1'b1;
            acc_log.push_back(m_data_o);
            n_acc++;
            if (m_last_o) last_word = int'(m_data_o);
        end
        if (start_i && !busy_exp && len_i == 0) nxt_done = 1'b1;
        if (done_due) busy_exp = 1'b0;
        else if (start_i && !busy_exp) busy_exp = 1'b1;
        done_due   = nxt_done;
        prev_stall = m_valid_o && !m_ready_i;
        prev_data  = m_data_o;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Push the expected stream, then pulse start for one cycle.
    task automatic begin_xfer(input int base, input int len, output int k);
        acc_log.delete(); addr_log.delete();
        n_en = 0; n_acc = 0; last_word = -1; done_cyc = 0;
        for (int j = 0; j < len; j++) begin
            b.data = WW'((base + j) % MEMSZ);
            b.last = (j == len - 1);
            exp_q.push_back(b);
            addr_q.push_back(AW'((base + j) % MEMSZ));
        end
        start_i = 1'b1; base_addr_i = AW'(base); len_i = (AW+1)'(len);
        k = cyc;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            if (done_o) break;
        end
        chk(name, done_o, 1);
        tick();
        chk("model_drained", (exp_q.size() == 0 && addr_q.size() == 0), 1);
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_busy"}, busy_o, 0);   chk({name, "_done"}, done_o, 0);
        chk({name, "_en"}, gb_en_o, 0);    chk({name, "_we"}, gb_we_o, 0);
        chk({name, "_valid"}, m_valid_o, 0); chk({name, "_last"}, m_last_o, 0);
        chk({name, "_addr"}, gb_addr_o, 0);  chk({name, "_data"}, m_data_o, 0);
    endtask

    int k;
    int exp_basic [4];
    int exp_wrap  [4];

    initial begin
        exp_basic = '{10, 11, 12, 13};
        exp_wrap  = '{MEMSZ - 2, MEMSZ - 1, 0, 1};

        // Reset state
        #2;
        check_idle_outputs("reset");
        tick(); tick();
        rst_ni = 1'b1;
        m_ready_i = 1'b1;

        // Basic read: base 10, len 4
        begin_xfer(10, 4, k);
        chk("basic_en_at_k1", gb_en_o, 1);
        chk("basic_addr_at_k1", gb_addr_o, 10);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            if (m_valid_o) break;
        end
        chk("basic_first_valid_latency", cyc - k, 3);
        wait_done("basic_done", 30);
        chk("basic_done_cycle", done_cyc - k, 7);
        chk("basic_count", acc_log.size(), 4);
        for (int i = 0; i < 4 && i < acc_log.size(); i++) chk("basic_word", acc_log[i], exp_basic[i]);
        chk("basic_last_word", last_word, 13);

        // Backpressure: ready low for 6 cycles mid-stream
        begin_xfer(40, 8, k);
        repeat (4) tick();
        m_ready_i = 1'b0;
        repeat (5) tick();
        chk("bp_en_stalled", gb_en_o, 0);
        chk("bp_issued_during_stall", n_en, 6);
        tick();
        m_ready_i = 1'b1;
        wait_done("bp_done", 60);
        chk("bp_count", acc_log.size(), 8);
        chk("bp_last_word", last_word, 47);

        // Address wrap
        begin_xfer(MEMSZ - 2, 4, k);
        wait_done("wrap_done", 30);
        chk("wrap_addr_count", addr_log.size(), 4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++) chk("wrap_addr", addr_log[i], exp_wrap[i]);

        // Zero length
        begin_xfer(7, 0, k);
        chk("zero_done_at_k1", done_o, 1);
        chk("zero_busy_at_k1", busy_o, 1);
        tick(); tick();
        chk("zero_done_cycle", done_cyc - k, 1);
        chk("zero_no_reads", n_en, 0);
        chk("zero_no_words", n_acc, 0);
        chk("zero_idle_after", busy_o, 0);

        // Reset mid-transfer, then a fresh transfer right after release
        begin_xfer(20, 8, k);
        repeat (4) tick();
        rst_ni = 1'b0;
        #1;
        check_idle_outputs("midreset");
        exp_q.delete(); addr_q.delete();
        busy_exp = 1'b0; done_due = 1'b0; prev_stall = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        begin_xfer(0, 2, k);
        wait_done("postreset_done", 30);
        chk("postreset_count", acc_log.size(), 2);
        if (acc_log.size() == 2) begin
            chk("postreset_word0", acc_log[0], 0);
            chk("postreset_word1", acc_log[1], 1);
        end

        // Start while busy is ignored
        begin_xfer(30, 6, k);
        repeat (2) tick();
        start_i = 1'b1; base_addr_i = AW'(0); len_i = (AW+1)'(3);
        tick();
        start_i = 1'b0;
        wait_done("busy_start_done", 40);
        chk("busy_start_count", acc_log.size(), 6);
        chk("busy_start_last", last_word, 35);

        // Full buffer with irregular ready
        begin_xfer(5, MEMSZ, k);
        for (int i = 0; i < 8 * MEMSZ; i++) begin
            m_ready_i = ((cyc % 4) != 3) && ((cyc % 11) != 5);
            tick();
            if (done_o) break;
        end
        chk("full_done", done_o, 1);
        m_ready_i = 1'b1;
        tick();
        chk("full_count", acc_log.size(), MEMSZ);
        if (acc_log.size() == MEMSZ) begin
            chk("full_word_wrap_hi", acc_log[MEMSZ - 6], MEMSZ - 1);
            chk("full_word_wrap_lo", acc_log[MEMSZ - 5], 0);
        end
        chk("full_last_word", last_word, 4);

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gbuff_reader.md
GBUFF_READER -- requirements
Module: gbuff_reader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output skid FIFO entries; legal values are powers of two and at least 2.
REQ-002 SHALL have port clk_i, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port start_i, input, 1 bit, one-cycle request to begin a transfer.
REQ-005 SHALL have port base_addr_i, input, `ADDR_WIDTH, first buffer address, sampled with start_i.
REQ-006 SHALL have port len_i, input, `ADDR_WIDTH+1, number of words to read, sampled with start_i.
REQ-007 SHALL have port busy_o, output, 1 bit, high while a transfer is active.
REQ-008 SHALL have port done_o, output, 1 bit, one-cycle pulse when a transfer completes.
REQ-009 SHALL have port gb_en_o, output, 1 bit, buffer enable.
REQ-010 SHALL have port gb_we_o, output, 1 bit, buffer write enable, tied 0.
REQ-011 SHALL have port gb_addr_o, output, `ADDR_WIDTH, buffer address.
REQ-012 SHALL have port gb_data_i, input, `WORD_WIDTH, buffer read data, valid the cycle after an enabled read.
REQ-013 SHALL have port m_valid_o, output, 1 bit, stream word valid.
REQ-014 SHALL have port m_ready_i, input, 1 bit, stream consumer ready.
REQ-015 SHALL have port m_data_o, output, `WORD_WIDTH, stream word.
REQ-016 SHALL have port m_last_o, output, 1 bit, marks the final word of a transfer.

Function
REQ-017 SHALL implement states IDLE, RUN and DONE: IDLE->RUN on start_i with len_i>0, IDLE->DONE on start_i with len_i==0, RUN->DONE when the last word is accepted (m_valid_o & m_ready_i & m_last_o), and DONE->IDLE unconditionally.
REQ-018 SHALL assert done_o for exactly the single cycle spent in DONE, and assert busy_o in RUN and DONE.
REQ-019 SHALL ignore start_i while busy_o is high.
REQ-020 SHALL issue a read (gb_en_o=1, gb_we_o=0) in a cycle only when in RUN, with issued<len, and FIFO occupancy plus in-flight reads < FIFO_DEPTH.
REQ-021 SHALL drive gb_addr_o = base + issued-count, wrapping modulo 2^`ADDR_WIDTH.
REQ-022 SHALL write gb_data_i into the FIFO on the cycle after each issued read, never dropping a word regardless of m_ready_i.
REQ-023 SHALL present the FIFO head on m_data_o with m_valid_o, hold m_data_o and m_valid_o stable while m_valid_o & !m_ready_i, and pop only on m_valid_o & m_ready_i.
REQ-024 SHALL first-word latency: start_i at cycle k -> gb_en_o at k+1 -> m_valid_o at k+3.
REQ-025 SHALL sustain one word per cycle while m_ready_i stays high.
REQ-026 SHALL assert m_last_o only together with m_valid_o, on word number len-1.
REQ-027 SHALL push and pop in the same cycle without changing occupancy, on a full FIFO as well.
REQ-028 SHALL support len=2^`ADDR_WIDTH (full buffer) without counter overflow.

Reset
REQ-029 SHALL on rst_ni low, asynchronously go to IDLE, clear all counters and FIFO pointers, and drive busy_o, done_o, gb_en_o, gb_we_o, m_valid_o and m_last_o to 0, with gb_addr_o and m_data_o at 0.
REQ-030 SHALL on reset mid-transfer, discard in-flight data, and accept a new start_i in the first cycle after release.

Structure
REQ-031 SHALL take `ADDR_WIDTH and `WORD_WIDTH from def.v, and add `GBRD_FIFO_DEPTH there as the default.
REQ-032 SHALL instantiate one sub-module sync_fifo (width `WORD_WIDTH, depth FIFO_DEPTH, async active-low reset, full/empty/count outputs).

Verification
REQ-033 SHALL verify a basic read: buffer preloaded mem[i]=i, start with base=10, len=4, m_ready_i=1 -> data 10,11,12,13, last on 13, m_valid_o first at k+3, done_o one cycle after 13.
REQ-034 SHALL verify backpressure: len=8, m_ready_i low for 6 cycles mid-stream -> gb_en_o stalls once FIFO_DEPTH words are buffered, no loss or duplication, order preserved.
REQ-035 SHALL verify address wrap: base=2^`ADDR_WIDTH-2, len=4 -> addresses MAX-1, MAX, 0, 1.
REQ-036 SHALL verify zero length: start with len=0 -> no gb_en_o, no m_valid_o, done_o at k+1.
REQ-037 SHALL verify reset mid-transfer: rst_ni low during word 3 of len=8 -> all outputs 0 immediately, and a fresh start (base=0, len=2) yields 0,1.
REQ-038 SHALL verify start while busy: start_i pulsed mid-transfer -> ignored, and the original stream completes unchanged.
